// File: rtl/aes_shift_rows.sv
// AES ShiftRows / InvShiftRows byte permutation with one output register stage.
// Optional macro SHIFT_ROWS_RUNTIME_INV_EN adds inv_sel to flip the direction at runtime.
module aes_shift_rows #(
    parameter int INVERSE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [127:0] input_state,
`ifdef SHIFT_ROWS_RUNTIME_INV_EN
    input  logic         inv_sel,
`endif
    output logic         out_valid,
    output logic [127:0] output_state
);

    logic         inv_eff;
    logic [127:0] fwd_state;
    logic [127:0] inv_state;
    logic [127:0] perm_state;

`ifdef SHIFT_ROWS_RUNTIME_INV_EN
    always_comb inv_eff = (INVERSE != 0) ^ inv_sel;
`else
    always_comb inv_eff = (INVERSE != 0);
`endif

    // Byte k = 4*col + row sits at bits [127-8k -: 8]; both directions are
    // pure wiring, so only the final select depends on inv_eff.
    for (genvar k = 0; k < 16; k++) begin : g_byte
        localparam int ROW     = k % 4;
        localparam int COL     = k / 4;
        localparam int SRC_FWD = 4 * ((COL + ROW) % 4) + ROW;
        localparam int SRC_INV = 4 * ((COL - ROW + 4) % 4) + ROW;

        assign fwd_state[127 - 8*k -: 8] = input_state[127 - 8*SRC_FWD -: 8];
        assign inv_state[127 - 8*k -: 8] = input_state[127 - 8*SRC_INV -: 8];
    end

    always_comb perm_state = inv_eff ? inv_state : fwd_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            output_state <= '0;
            out_valid    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                output_state <= perm_state;
            end
        end
    end

endmodule

// File: tb/tb_aes_shift_rows.sv
// Self-checking bench for aes_shift_rows: forward and inverse instances against a
// row-rotation reference model; covers inv_sel when SHIFT_ROWS_RUNTIME_INV_EN is defined.
module tb_aes_shift_rows;

    logic         clk = 1'b0;
    logic         rst;
    logic         f_iv, i_iv;
    logic [127:0] f_in, i_in;
    logic         f_sel, i_sel;
    logic         f_ov, i_ov;
    logic [127:0] f_out, i_out;

    int errors = 0;
    int checks = 0;

    logic [127:0] ef, ei, orig;
    logic         efv, eiv;

    always #5 clk = ~clk;

    aes_shift_rows #(.INVERSE(0)) dut_fwd (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (f_iv),
        .input_state  (f_in),
`ifdef SHIFT_ROWS_RUNTIME_INV_EN
        .inv_sel      (f_sel),
`endif
        .out_valid    (f_ov),
        .output_state (f_out)
    );

    aes_shift_rows #(.INVERSE(1)) dut_inv (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (i_iv),
        .input_state  (i_in),
`ifdef SHIFT_ROWS_RUNTIME_INV_EN
        .inv_sel      (i_sel),
`endif
        .out_valid    (i_ov),
        .output_state (i_out)
    );

    // Reference: gather each row into a 32-bit word (column 0 in the MSB byte)
    // and rotate it by 8*row bits, left for forward, right for inverse.
    function automatic logic [127:0] ref_shift(input logic [127:0] s, input bit inv);
        logic [31:0]  row [4];
        logic [31:0]  w;
        logic [127:0] o;
        logic [7:0]   b;
        for (int r = 0; r < 4; r++) row[r] = '0;
        for (int k = 0; k < 16; k++) begin
            b = 8'((s >> (120 - 8*k)) & 128'hff);
            row[k % 4] = row[k % 4] | (32'(b) << (24 - 8*(k / 4)));
        end
        for (int r = 0; r < 4; r++) begin
            w = row[r];
            if (r != 0) begin
                if (inv) row[r] = (w >> (8*r)) | (w << (32 - 8*r));
                else     row[r] = (w << (8*r)) | (w >> (32 - 8*r));
            end
        end
        o = '0;
        for (int k = 0; k < 16; k++) begin
            b = 8'((row[k % 4] >> (24 - 8*(k / 4))) & 32'hff);
            o = o | (128'(b) << (120 - 8*k));
        end
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "_fwd_valid"}, 128'(f_ov), 128'(efv));
        check({tag, "_fwd_out"},   f_out,      ef);
        check({tag, "_inv_valid"}, 128'(i_ov), 128'(eiv));
        check({tag, "_inv_out"},   i_out,      ei);
    endtask

    initial begin
        rst = 1'b1; f_iv = 1'b0; i_iv = 1'b0; f_sel = 1'b0; i_sel = 1'b0;
        f_in = rnd128(); i_in = rnd128();
        tick();

        // Reset wins over a simultaneous valid input
        f_iv = 1'b1; i_iv = 1'b1;
        f_in = 128'hd42711aee0bf98f1b8b45de51e415230;
        i_in = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        tick();
        ef = '0; efv = 1'b0; ei = '0; eiv = 1'b0;
        check_both("rst_with_valid");

        rst = 1'b0; f_iv = 1'b0; i_iv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f_in = 'x; i_in = 'x;
            tick();
            check_both("idle_after_rst");
        end

        // Known-answer vectors (FIPS-197 round 1 and a counting state)
        f_iv = 1'b1; i_iv = 1'b1;
        f_in = 128'hd42711aee0bf98f1b8b45de51e415230;
        i_in = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        tick();
        check("kat1_fwd_out", f_out, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        check("kat1_fwd_valid", 128'(f_ov), 128'd1);
        check("kat2_inv_out", i_out, 128'hd42711aee0bf98f1b8b45de51e415230);
        check("kat2_inv_valid", 128'(i_ov), 128'd1);
        check("kat1_model", ref_shift(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0), f_out);

        orig = 128'h000102030405060708090a0b0c0d0e0f;
        f_in = orig; i_iv = 1'b0;
        tick();
        check("kat3_fwd_out", f_out, 128'h00050a0f04090e03080d02070c01060b);
        i_in = f_out; i_iv = 1'b1; f_iv = 1'b0;
        tick();
        check("kat3_roundtrip", i_out, orig);
        check("kat3_fwd_valid_drop", 128'(f_ov), 128'd0);

        // Back-to-back throughput, then hold with random input
        f_iv = 1'b1; i_iv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f_in = rnd128(); i_in = rnd128();
            ef = ref_shift(f_in, 1'b0); ei = ref_shift(i_in, 1'b1);
            efv = 1'b1; eiv = 1'b1;
            tick();
            check_both("stream");
        end
        f_iv = 1'b0; i_iv = 1'b0; efv = 1'b0; eiv = 1'b0;
        for (int i = 0; i < 2; i++) begin
            f_in = rnd128(); i_in = rnd128();
            tick();
            check_both("hold");
        end

        // Mid-stream reset discards the in-flight state
        f_iv = 1'b1; i_iv = 1'b1;
        f_in = rnd128(); i_in = rnd128();
        ef = ref_shift(f_in, 1'b0); ei = ref_shift(i_in, 1'b1); efv = 1'b1; eiv = 1'b1;
        tick();
        check_both("pre_midrst");
        rst = 1'b1; f_in = rnd128(); i_in = rnd128();
        tick();
        ef = '0; ei = '0; efv = 1'b0; eiv = 1'b0;
        check_both("midrst");
        rst = 1'b0; f_in = rnd128(); i_in = rnd128();
        ef = ref_shift(f_in, 1'b0); ei = ref_shift(i_in, 1'b1); efv = 1'b1; eiv = 1'b1;
        tick();
        check_both("post_midrst");

`ifdef SHIFT_ROWS_RUNTIME_INV_EN
        f_sel = 1'b1; f_in = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        tick();
        check("sel1_fwd_inst", f_out, 128'hd42711aee0bf98f1b8b45de51e415230);
        f_sel = 1'b0; f_in = 128'hd42711aee0bf98f1b8b45de51e415230;
        tick();
        check("sel0_fwd_inst", f_out, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        i_sel = 1'b1; i_in = 128'hd42711aee0bf98f1b8b45de51e415230;
        tick();
        check("sel1_inv_inst", i_out, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        i_sel = 1'b0;
        ef = f_out; ei = i_out;
`endif

        // Randomized traffic with occasional reset
        for (int i = 0; i < 60; i++) begin
            rst  = ($urandom_range(15) == 0);
            f_iv = $urandom_range(1); i_iv = $urandom_range(1);
`ifdef SHIFT_ROWS_RUNTIME_INV_EN
            f_sel = $urandom_range(1); i_sel = $urandom_range(1);
`endif
            f_in = rnd128(); i_in = rnd128();
            if (rst) begin
                ef = '0; ei = '0; efv = 1'b0; eiv = 1'b0;
            end else begin
                efv = f_iv; eiv = i_iv;
                if (f_iv) ef = ref_shift(f_in, 1'b0 ^ f_sel);
                if (i_iv) ei = ref_shift(i_in, 1'b1 ^ i_sel);
            end
            tick();
            check_both("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
